// File: rtl/mem_64_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_64_pkg                                                                 |
// | Constants and default-layout helpers for the 6x6 memory-game card store.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package mem_64_pkg;

    localparam int              DEPTH       = 64;
    localparam int              AW          = 6;
    localparam int              DW          = 5;
    localparam int              BOARD_CELLS = 36;
    localparam int              NUM_PAIRS   = 18;
    localparam logic [DW-1:0]   EMPTY_VAL   = 5'd31;

    typedef logic [DEPTH-1:0][DW-1:0] mem_image_t;

    // Board cell a holds a mod 18, so each pair sits at a and a+18.
    function automatic logic [DW-1:0] default_card(input logic [AW-1:0] addr);
        if (addr < AW'(BOARD_CELLS))
            return DW'(addr % AW'(NUM_PAIRS));
        else
            return EMPTY_VAL;
    endfunction

    function automatic mem_image_t default_image();
        mem_image_t img;
        for (int i = 0; i < DEPTH; i++)
            img[i] = default_card(AW'(i));
        return img;
    endfunction

endpackage : mem_64_pkg
`default_nettype wire

// File: rtl/mem_64_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_64_if                                                                  |
// | Read/write bus of mem_64; write signals exist only with MEM_64_WRITE_EN.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_64_if;
    import mem_64_pkg::*;

    logic [AW-1:0] rAddr;
    logic [DW-1:0] dataOut;
    logic          rValid;
`ifdef MEM_64_WRITE_EN
    logic          we;
    logic [AW-1:0] wAddr;
    logic [DW-1:0] wData;
`endif

    modport master (
`ifdef MEM_64_WRITE_EN
        output we,
        output wAddr,
        output wData,
`endif
        output rAddr,
        input  dataOut,
        input  rValid
    );

    modport slave (
`ifdef MEM_64_WRITE_EN
        input  we,
        input  wAddr,
        input  wData,
`endif
        input  rAddr,
        output dataOut,
        output rValid
    );

endinterface : mem_64_if
`default_nettype wire

// File: rtl/mem_64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_64                                                                     |
// | 64x5 register card store with one-cycle registered read. Defining          |
// | MEM_64_WRITE_EN adds a write-first write port; otherwise it is a ROM.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_64
    import mem_64_pkg::*;
(
    input  wire    clock,
    input  wire    reset,
    mem_64_if.slave bus
);

    // Declaration initialiser gives the default layout at power-up as well.
    mem_image_t    r_mem = default_image();
    logic [DW-1:0] r_data;
    logic          r_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem   <= default_image();
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
`ifdef MEM_64_WRITE_EN
            if (bus.we)
                r_mem[bus.wAddr] <= bus.wData;
            r_data <= (bus.we && (bus.wAddr == bus.rAddr)) ? bus.wData
                                                           : r_mem[bus.rAddr];
`else
            r_data <= r_mem[bus.rAddr];
`endif
            r_valid <= (bus.rAddr < AW'(BOARD_CELLS));
        end
    end

    assign bus.dataOut = r_data;
    assign bus.rValid  = r_valid;

endmodule : mem_64
`default_nettype wire

// File: tb/tb_mem_64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_64                                                                  |
// | Vector-table bench for mem_64; write-port sequences need MEM_64_WRITE_EN.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    mem_64_if bus();

    mem_64 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [5:0] addr;
        logic [4:0] exp_data;
        logic       exp_valid;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Drive at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic [5:0] ra,
                        input logic wen, input logic [5:0] wa, input logic [4:0] wd);
        @(negedge clock);
        reset     = rst;
        bus.rAddr = ra;
`ifdef MEM_64_WRITE_EN
        bus.we    = wen;
        bus.wAddr = wa;
        bus.wData = wd;
`else
        if (wen || (wa != 6'd0) || (wd != 5'd0)) ;
`endif
        @(posedge clock);
        #1;
    endtask

    int cnt[32];

    initial begin
        bus.rAddr = 6'd7;
`ifdef MEM_64_WRITE_EN
        bus.we    = 1'b0;
        bus.wAddr = '0;
        bus.wData = '0;
`endif
        // Power-up contents without any reset.
        @(posedge clock);
        #1;
        check("powerup_data", bus.dataOut, 7);
        check("powerup_valid", bus.rValid, 1);

        vecs[0]  = '{1'b1, 6'd0,  5'd0,  1'b0};
        vecs[1]  = '{1'b1, 6'd0,  5'd0,  1'b0};
        vecs[2]  = '{1'b0, 6'd0,  5'd0,  1'b1};
        vecs[3]  = '{1'b0, 6'd17, 5'd17, 1'b1};
        vecs[4]  = '{1'b0, 6'd18, 5'd0,  1'b1};
        vecs[5]  = '{1'b0, 6'd35, 5'd17, 1'b1};
        vecs[6]  = '{1'b0, 6'd36, 5'd31, 1'b0};
        vecs[7]  = '{1'b0, 6'd63, 5'd31, 1'b0};
        vecs[8]  = '{1'b1, 6'd20, 5'd0,  1'b0};
        vecs[9]  = '{1'b0, 6'd20, 5'd2,  1'b1};
        vecs[10] = '{1'b0, 6'd1,  5'd1,  1'b1};
        vecs[11] = '{1'b0, 6'd19, 5'd1,  1'b1};
        vecs[12] = '{1'b0, 6'd34, 5'd16, 1'b1};
        vecs[13] = '{1'b0, 6'd50, 5'd31, 1'b0};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].addr, 1'b0, 6'd0, 5'd0);
            check($sformatf("vec%0d_data", i), bus.dataOut, vecs[i].exp_data);
            check($sformatf("vec%0d_valid", i), bus.rValid, vecs[i].exp_valid);
        end

        // Output holds across the cycle even though rAddr has already moved.
        @(negedge clock);
        bus.rAddr = 6'd3;
        #2;
        check("hold_data", bus.dataOut, 31);

        // Sweep the board: every value 0..17 appears exactly twice.
        for (int v = 0; v < 32; v++) cnt[v] = 0;
        for (int a = 0; a < 36; a++) begin
            step(1'b0, 6'(a), 1'b0, 6'd0, 5'd0);
            cnt[bus.dataOut]++;
        end
        for (int v = 0; v < 18; v++)
            check($sformatf("sweep_count_%0d", v), cnt[v], 2);
        check("sweep_count_31", cnt[31], 0);

`ifdef MEM_64_WRITE_EN
        step(1'b0, 6'd5, 1'b1, 6'd5, 5'd9);
        check("wr_first", bus.dataOut, 9);
        step(1'b0, 6'd5, 1'b0, 6'd5, 5'd0);
        check("wr_readback", bus.dataOut, 9);
        step(1'b0, 6'd5, 1'b1, 6'd40, 5'd7);
        check("wr_other_addr", bus.dataOut, 9);
        step(1'b0, 6'd40, 1'b0, 6'd0, 5'd0);
        check("wr_offboard_data", bus.dataOut, 7);
        check("wr_offboard_valid", bus.rValid, 0);
        step(1'b1, 6'd6, 1'b1, 6'd6, 5'd3);
        check("rst_vs_wr_data", bus.dataOut, 0);
        check("rst_vs_wr_valid", bus.rValid, 0);
        step(1'b0, 6'd5, 1'b0, 6'd0, 5'd0);
        check("rst_discard_5", bus.dataOut, 5);
        step(1'b0, 6'd6, 1'b0, 6'd0, 5'd0);
        check("rst_discard_6", bus.dataOut, 6);
        step(1'b0, 6'd40, 1'b0, 6'd0, 5'd0);
        check("rst_discard_40", bus.dataOut, 31);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_64
`default_nettype wire
